// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: state encoding, grant ids, default widths.
package mem_arb_pkg;

   localparam int AW_DEF = 32;
   localparam int DW_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on contention the side that did not win last time wins.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic req_i,
   input  logic req_d,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   always_comb begin
      grant_valid = req_i | req_d;
      grant_id    = GNT_I;
      if (req_i && req_d) begin
         grant_id = ~last_grant;
      end else if (req_d) begin
         grant_id = GNT_D;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data requesters onto one shared memory port.
// Optional watchdog on m_ack enabled by defining MEMARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW             = AW_DEF,
   parameter int DW             = DW_DEF,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ready,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ready,
   output logic [DW-1:0] d_rdata,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   output logic          m_read,
   output logic          m_write,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ack,
   output logic          err
);

   arb_state_t    state_reg, state_next;
   logic          last_grant_reg, last_grant_next;
   logic [AW-1:0] m_addr_reg, m_addr_next;
   logic [DW-1:0] m_wdata_reg, m_wdata_next;
   logic          m_read_reg, m_read_next;
   logic          m_write_reg, m_write_next;
   logic [DW-1:0] i_rdata_reg, i_rdata_next;
   logic [DW-1:0] d_rdata_reg, d_rdata_next;
   logic          i_ready_reg, i_ready_next;
   logic          d_ready_reg, d_ready_next;
   logic          grant_valid;
   logic          grant_id;

`ifdef MEMARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             err_reg, err_next;
`endif

   rr_pick2 u_pick (
      .req_i       (i_req),
      .req_d       (d_req),
      .last_grant  (last_grant_reg),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      m_addr_next     = m_addr_reg;
      m_wdata_next    = m_wdata_reg;
      m_read_next     = m_read_reg;
      m_write_next    = m_write_reg;
      i_rdata_next    = i_rdata_reg;
      d_rdata_next    = d_rdata_reg;
      i_ready_next    = 1'b0;
      d_ready_next    = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
      cnt_next        = cnt_reg;
      err_next        = err_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (grant_valid) begin
               last_grant_next = grant_id;
`ifdef MEMARB_TIMEOUT_EN
               cnt_next = '0;
`endif
               if (grant_id == GNT_I) begin
                  state_next   = I_BUSY;
                  m_addr_next  = i_addr;
                  m_read_next  = 1'b1;
                  m_write_next = 1'b0;
               end else begin
                  state_next   = D_BUSY;
                  m_addr_next  = d_addr;
                  m_wdata_next = d_wdata;
                  m_read_next  = ~d_we;
                  m_write_next = d_we;
               end
            end
         end
         I_BUSY, D_BUSY: begin
            if (m_ack) begin
               m_read_next  = 1'b0;
               m_write_next = 1'b0;
               state_next   = RESP;
               if (state_reg == I_BUSY) begin
                  i_rdata_next = m_rdata;
                  i_ready_next = 1'b1;
               end else begin
                  // Writes return no data, so the load result is left untouched.
                  if (!m_write_reg) begin
                     d_rdata_next = m_rdata;
                  end
                  d_ready_next = 1'b1;
               end
            end
`ifdef MEMARB_TIMEOUT_EN
            else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               m_read_next  = 1'b0;
               m_write_next = 1'b0;
               err_next     = 1'b1;
               state_next   = RESP;
               i_ready_next = (state_reg == I_BUSY);
               d_ready_next = (state_reg == D_BUSY);
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
`endif
         end
         RESP: begin
            // Requests are deliberately not sampled here.
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg      <= IDLE;
         last_grant_reg <= GNT_D;
         m_addr_reg     <= '0;
         m_wdata_reg    <= '0;
         m_read_reg     <= 1'b0;
         m_write_reg    <= 1'b0;
         i_rdata_reg    <= '0;
         d_rdata_reg    <= '0;
         i_ready_reg    <= 1'b0;
         d_ready_reg    <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
         cnt_reg        <= '0;
         err_reg        <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         m_addr_reg     <= m_addr_next;
         m_wdata_reg    <= m_wdata_next;
         m_read_reg     <= m_read_next;
         m_write_reg    <= m_write_next;
         i_rdata_reg    <= i_rdata_next;
         d_rdata_reg    <= d_rdata_next;
         i_ready_reg    <= i_ready_next;
         d_ready_reg    <= d_ready_next;
`ifdef MEMARB_TIMEOUT_EN
         cnt_reg        <= cnt_next;
         err_reg        <= err_next;
`endif
      end
   end

   assign m_addr  = m_addr_reg;
   assign m_wdata = m_wdata_reg;
   assign m_read  = m_read_reg;
   assign m_write = m_write_reg;
   assign i_rdata = i_rdata_reg;
   assign d_rdata = d_rdata_reg;
   assign i_ready = i_ready_reg;
   assign d_ready = d_ready_reg;
`ifdef MEMARB_TIMEOUT_EN
   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; set MEMARB_TIMEOUT_EN to cover the watchdog.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_ready;
   logic [DW-1:0] i_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ready;
   logic [DW-1:0] d_rdata;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_read;
   logic          m_write;
   logic [DW-1:0] m_rdata;
   logic          m_ack;
   logic          err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [DW-1:0] exp_d_rdata;
   logic [DW-1:0] exp_i_rdata;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(15)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_ready (i_ready),
      .i_rdata (i_rdata),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_ready (d_ready),
      .d_rdata (d_rdata),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_read  (m_read),
      .m_write (m_write),
      .m_rdata (m_rdata),
      .m_ack   (m_ack),
      .err     (err)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "simulation time limit");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_bad++;
         $error("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".i_ready"}, 64'(i_ready), 64'd0);
      check({tag, ".d_ready"}, 64'(d_ready), 64'd0);
      check({tag, ".i_rdata"}, 64'(i_rdata), 64'd0);
      check({tag, ".d_rdata"}, 64'(d_rdata), 64'd0);
      check({tag, ".m_addr"},  64'(m_addr),  64'd0);
      check({tag, ".m_wdata"}, 64'(m_wdata), 64'd0);
      check({tag, ".m_read"},  64'(m_read),  64'd0);
      check({tag, ".m_write"}, 64'(m_write), 64'd0);
      check({tag, ".err"},     64'(err),     64'd0);
   endtask

   // Continuous-contention read: expect a grant to the named side, ack with zero wait.
   task automatic contended_read(input bit to_i, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      tick();
      check("rr.m_addr", 64'(m_addr), 64'(addr));
      check("rr.m_read", 64'(m_read), 64'd1);
      m_ack = 1'b1;
      m_rdata = data;
      tick();
      m_ack = 1'b0;
      check("rr.i_ready", 64'(i_ready), 64'(to_i));
      check("rr.d_ready", 64'(d_ready), 64'(!to_i));
      if (to_i) exp_i_rdata = data;
      else exp_d_rdata = data;
      check("rr.i_rdata", 64'(i_rdata), 64'(exp_i_rdata));
      check("rr.d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
      tick();
      check("rr.no_grant_in_resp", 64'({m_read, m_write}), 64'd0);
      $display("txn rr grant=%s addr=%0h data=%0h", to_i ? "I" : "D", addr, data);
   endtask

   initial begin
      Reset = 1'b1;
      i_req = 1'b0;
      i_addr = '0;
      d_req = 1'b0;
      d_we = 1'b0;
      d_addr = '0;
      d_wdata = '0;
      m_rdata = '0;
      m_ack = 1'b0;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      tick();
      tick();
      check_idle_outputs("reset");
      Reset = 1'b0;

      // 1: single instruction fetch, zero wait
      i_req = 1'b1;
      i_addr = 32'h10;
      tick();
      check("t1.m_addr", 64'(m_addr), 64'h10);
      check("t1.m_read", 64'(m_read), 64'd1);
      check("t1.m_write", 64'(m_write), 64'd0);
      check("t1.i_ready_early", 64'(i_ready), 64'd0);
      m_ack = 1'b1;
      m_rdata = 32'h2408000A;
      tick();
      m_ack = 1'b0;
      i_req = 1'b0;
      check("t1.m_read_drop", 64'(m_read), 64'd0);
      check("t1.i_ready", 64'(i_ready), 64'd1);
      check("t1.i_rdata", 64'(i_rdata), 64'h2408000A);
      check("t1.d_ready", 64'(d_ready), 64'd0);
      tick();
      check("t1.i_ready_pulse", 64'(i_ready), 64'd0);
      check("t1.m_write", 64'(m_write), 64'd0);
      exp_i_rdata = 32'h2408000A;
      $display("txn t1 ifetch addr=10 data=%0h", i_rdata);

      // 2: data write with three wait cycles
      d_req = 1'b1;
      d_we = 1'b1;
      d_addr = 32'h40;
      d_wdata = 32'hDEADBEEF;
      tick();
      for (int k = 0; k < 4; k++) begin
         check("t2.m_write", 64'(m_write), 64'd1);
         check("t2.m_read", 64'(m_read), 64'd0);
         check("t2.m_addr", 64'(m_addr), 64'h40);
         check("t2.m_wdata", 64'(m_wdata), 64'hDEADBEEF);
         check("t2.d_ready_early", 64'(d_ready), 64'd0);
         if (k < 3) tick();
      end
      m_ack = 1'b1;
      m_rdata = 32'h12345678;
      tick();
      m_ack = 1'b0;
      d_req = 1'b0;
      d_we = 1'b0;
      check("t2.m_write_drop", 64'(m_write), 64'd0);
      check("t2.d_ready", 64'(d_ready), 64'd1);
      check("t2.d_rdata_kept", 64'(d_rdata), 64'(exp_d_rdata));
      tick();
      check("t2.d_ready_pulse", 64'(d_ready), 64'd0);
      $display("txn t2 dwrite addr=40 data=deadbeef");

      // 3: continuous contention from reset alternates I, D, I, D
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      i_req = 1'b1;
      i_addr = 32'h100;
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = 32'h200;
      contended_read(1'b1, 32'h100, 32'hA0000001);
      contended_read(1'b0, 32'h200, 32'hB0000002);
      contended_read(1'b1, 32'h100, 32'hA0000003);
      contended_read(1'b0, 32'h200, 32'hB0000004);
      i_req = 1'b0;
      d_req = 1'b0;
      tick();

      // 4: reset while busy aborts; late ack ignored
      i_req = 1'b1;
      i_addr = 32'h20;
      tick();
      check("t4.m_addr", 64'(m_addr), 64'h20);
      check("t4.m_read", 64'(m_read), 64'd1);
      i_req = 1'b0;
      Reset = 1'b1;
      tick();
      check_idle_outputs("t4.reset");
      Reset = 1'b0;
      m_ack = 1'b1;
      m_rdata = 32'hBAD0BAD0;
      tick();
      m_ack = 1'b0;
      check_idle_outputs("t4.late_ack");
      i_req = 1'b1;
      i_addr = 32'h30;
      tick();
      check("t4b.m_addr", 64'(m_addr), 64'h30);
      check("t4b.m_read", 64'(m_read), 64'd1);
      m_ack = 1'b1;
      m_rdata = 32'h00000055;
      tick();
      m_ack = 1'b0;
      i_req = 1'b0;
      check("t4b.i_ready", 64'(i_ready), 64'd1);
      check("t4b.i_rdata", 64'(i_rdata), 64'h55);
      tick();
      exp_d_rdata = '0;
      $display("txn t4 reset-abort then ifetch addr=30 data=55");

      // 5: data read with no ack
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = 32'h44;
      tick();
`ifdef MEMARB_TIMEOUT_EN
      for (int k = 0; k < 14; k++) begin
         check("t5.m_read_held", 64'(m_read), 64'd1);
         check("t5.err_low", 64'(err), 64'd0);
         tick();
      end
      check("t5.m_read_15", 64'(m_read), 64'd1);
      tick();
      d_req = 1'b0;
      check("t5.m_read_drop", 64'(m_read), 64'd0);
      check("t5.err", 64'(err), 64'd1);
      check("t5.d_ready", 64'(d_ready), 64'd1);
      check("t5.d_rdata_kept", 64'(d_rdata), 64'(exp_d_rdata));
      tick();
      tick();
      check("t5.err_sticky", 64'(err), 64'd1);
      check("t5.d_ready_pulse", 64'(d_ready), 64'd0);
      $display("txn t5 dread addr=44 timeout err=%0b", err);
`else
      for (int k = 0; k < 20; k++) begin
         check("t5.m_read_held", 64'(m_read), 64'd1);
         check("t5.err_zero", 64'(err), 64'd0);
         tick();
      end
      m_ack = 1'b1;
      m_rdata = 32'h0000C0DE;
      tick();
      m_ack = 1'b0;
      d_req = 1'b0;
      check("t5.d_ready", 64'(d_ready), 64'd1);
      check("t5.d_rdata", 64'(d_rdata), 64'hC0DE);
      tick();
      $display("txn t5 dread addr=44 waited, data=%0h", d_rdata);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
